// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA modular-exponentiation job scheduler.
package rsa_pkg;

  localparam int unsigned DefaultWidth   = 32;
  localparam int unsigned DefaultTimeout = DefaultWidth * 2 + 4;

  // WAIT-cycle budget: one engine cycle per exponent bit plus start/latch margin.
  function automatic int unsigned timeout_cycles(input int unsigned width);
    return width * 2 + 4;
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait,
    StResp
  } state_e;

endpackage

// File: rtl/rsa_modexp_scheduler_if.sv
// Request, engine and response signals of the modexp scheduler.
interface rsa_modexp_scheduler_if #(
  parameter int unsigned WIDTH = rsa_pkg::DefaultWidth
);
  localparam int unsigned OpW = WIDTH * 2;

  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [OpW-1:0] req_base0;
  logic [OpW-1:0] req_exp0;
  logic [OpW-1:0] req_mod0;
  logic [OpW-1:0] req_base1;
  logic [OpW-1:0] req_exp1;
  logic [OpW-1:0] req_mod1;

  logic           eng_start;
  logic [OpW-1:0] eng_base;
  logic [OpW-1:0] eng_exp;
  logic [OpW-1:0] eng_mod;
  logic           eng_finish;
  logic [OpW-1:0] eng_result;

  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic [OpW-1:0] rsp_result;
  logic           rsp_err;
  logic           busy;

  // Scheduler side.
  modport master (
    input  req_valid, req_base0, req_exp0, req_mod0, req_base1, req_exp1, req_mod1,
    output req_ready,
    output eng_start, eng_base, eng_exp, eng_mod,
    input  eng_finish, eng_result,
    output rsp_valid, rsp_id, rsp_result, rsp_err, busy,
    input  rsp_ready
  );

  // Requesters, engine and response consumer.
  modport slave (
    output req_valid, req_base0, req_exp0, req_mod0, req_base1, req_exp1, req_mod1,
    input  req_ready,
    input  eng_start, eng_base, eng_exp, eng_mod,
    output eng_finish, eng_result,
    input  rsp_valid, rsp_id, rsp_result, rsp_err, busy,
    output rsp_ready
  );

endinterface

// File: rtl/rsa_rr_arb2.sv
// Two-way round-robin arbiter with a registered last-grant pointer.
module rsa_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // High when requester 1 held the most recent grant.
  logic last_q;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = last_q ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (|gnt) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/rsa_modexp_scheduler.sv
// Arbitrates two requesters onto one external mod_exp engine and returns results.
module rsa_modexp_scheduler
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH   = DefaultWidth,
  parameter int unsigned TIMEOUT = timeout_cycles(WIDTH)
) (
  input logic                    clk,
  input logic                    reset,
  rsa_modexp_scheduler_if.master bus
);

  localparam int unsigned OpW  = WIDTH * 2;
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  state_e state_q, state_d;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [OpW-1:0]  eng_base_q, eng_exp_q, eng_mod_q;
  logic [OpW-1:0]  rsp_result_q;
  logic            rsp_err_q;
  logic            rsp_id_q;

  logic [1:0]      gnt;
  logic            arb_en;
  logic            sel;
  logic [OpW-1:0]  sel_base, sel_exp, sel_mod;
  logic            mod_bad;
  logic            capture;
  logic            finish_ok;
  logic            timed_out;

  assign arb_en = (state_q == StIdle) && !reset;

  rsa_rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (arb_en),
    .req   (bus.req_valid),
    .gnt   (gnt)
  );

  assign bus.req_ready = gnt;

  assign sel      = gnt[1];
  assign sel_base = sel ? bus.req_base1 : bus.req_base0;
  assign sel_exp  = sel ? bus.req_exp1  : bus.req_exp0;
  assign sel_mod  = sel ? bus.req_mod1  : bus.req_mod0;
  // Modulo 0 or 1 has no meaningful result, so the engine is bypassed.
  assign mod_bad  = (sel_mod[OpW-1:1] == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    finish_ok = 1'b0;
    timed_out = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|gnt) begin
          capture = 1'b1;
          state_d = mod_bad ? StResp : StStart;
        end
      end
      StStart: begin
        // Finish is still high from the previous job here; not sampled.
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (bus.eng_finish) begin
          finish_ok = 1'b1;
          state_d   = StResp;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          timed_out = 1'b1;
          state_d   = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      eng_base_q   <= '0;
      eng_exp_q    <= '0;
      eng_mod_q    <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      rsp_id_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        eng_base_q <= sel_base;
        eng_exp_q  <= sel_exp;
        eng_mod_q  <= sel_mod;
        rsp_id_q   <= sel;
        if (mod_bad) begin
          rsp_err_q    <= 1'b1;
          rsp_result_q <= '0;
        end
      end
      if (finish_ok) begin
        rsp_err_q    <= 1'b0;
        rsp_result_q <= bus.eng_result;
      end
      if (timed_out) begin
        rsp_err_q    <= 1'b1;
        rsp_result_q <= '0;
      end
    end
  end

  assign bus.eng_start  = (state_q == StStart);
  assign bus.eng_base   = eng_base_q;
  assign bus.eng_exp    = eng_exp_q;
  assign bus.eng_mod    = eng_mod_q;
  assign bus.rsp_valid  = (state_q == StResp);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.busy       = (state_q != StIdle);

endmodule
